// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB responder with a word-addressed register file, wait-state insertion and error response.
// Register 0 is a read-only ID word; register 1 is exported as ctrl_out.
module apb_slave_regfile #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          ADDR_W      = 8,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA2B0_0001
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        Psel,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        Pready,
    output logic        Pslverr,
    output logic [31:0] ctrl_out
);
    localparam int IW = ADDR_W - 2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic          write_q;
    logic          err_q;
    logic [3:0]    cnt_q;
    logic [31:0]   prdata_q;
    logic          pready_q;
    logic          pslverr_q;
    logic [31:0]   regs_q [NUM_REGS-1:1];

    logic [IW-1:0] live_idx;
    logic [IW-1:0] cur_idx;
    logic          live_err;
    logic          cur_err;
    logic          cur_wr;
    logic [31:0]   rd_data;

    // In IDLE the live bus decode is used so a zero-wait read can respond straight from setup.
    always_comb begin
        live_idx = Paddr[ADDR_W-1:2];
        live_err = (Paddr[31:ADDR_W] != BASE_ADDR[31:ADDR_W]) || (Paddr[1:0] != 2'b00)
                 || (32'(live_idx) >= NUM_REGS) || (Pwrite && live_idx == '0);
        cur_idx  = (state_q == IDLE) ? live_idx : idx_q;
        cur_err  = (state_q == IDLE) ? live_err : err_q;
        cur_wr   = (state_q == IDLE) ? Pwrite : write_q;
        rd_data  = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++)
            if (32'(cur_idx) == i) rd_data = regs_q[i];
        if (cur_err || cur_wr) rd_data = '0;
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            case (state_q)
                IDLE: if (Psel && !Penable) begin
                    idx_q   <= live_idx;
                    write_q <= Pwrite;
                    err_q   <= live_err;
                    cnt_q   <= 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_q   <= RESP;
                        pready_q  <= 1'b1;
                        pslverr_q <= live_err;
                        prdata_q  <= rd_data;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: if (!Psel) begin
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q   <= RESP;
                        pready_q  <= 1'b1;
                        pslverr_q <= err_q;
                        prdata_q  <= rd_data;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    for (int i = 1; i < NUM_REGS; i++)
                        if (Psel && write_q && !err_q && 32'(idx_q) == i) regs_q[i] <= Pwdata;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Prdata   = prdata_q;
    assign Pready   = pready_q;
    assign Pslverr  = pslverr_q;
    assign ctrl_out = regs_q[1];
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: directed bench over three instances (1, 0 and 3 wait states) sharing one APB bus.
module tb_apb_slave_regfile;
    localparam int WS [3] = '{1, 0, 3};

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        bit          rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata [3];
    logic        pready [3];
    logic        pslverr [3];
    logic [31:0] ctrl [3];

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    apb_slave_regfile #(.WAIT_STATES(WS[0])) u0 (
        .Hclk(clk), .Hreset(rst), .Psel(psel[0]), .Penable(penable), .Pwrite(pwrite),
        .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata[0]), .Pready(pready[0]),
        .Pslverr(pslverr[0]), .ctrl_out(ctrl[0]));
    apb_slave_regfile #(.WAIT_STATES(WS[1])) u1 (
        .Hclk(clk), .Hreset(rst), .Psel(psel[1]), .Penable(penable), .Pwrite(pwrite),
        .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata[1]), .Pready(pready[1]),
        .Pslverr(pslverr[1]), .ctrl_out(ctrl[1]));
    apb_slave_regfile #(.WAIT_STATES(WS[2])) u2 (
        .Hclk(clk), .Hreset(rst), .Psel(psel[2]), .Penable(penable), .Pwrite(pwrite),
        .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata[2]), .Pready(pready[2]),
        .Pslverr(pslverr[2]), .ctrl_out(ctrl[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input string tag, input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic err, input logic [31:0] rdata);
        exp_t e;
        int   n;
        sb.push_back('{rdata: rdata, err: err, lat: WS[d], rd: !wr});
        @(posedge clk); #1;
        psel = 3'(1 << d); penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(negedge clk);
        chk({tag, "/setup_ready"}, 32'(pready[d]), 32'd0);
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        @(negedge clk);
        while (!pready[d] && n < 20) begin
            chk({tag, "/wait_prdata"}, prdata[d], 32'd0);
            chk({tag, "/wait_slverr"}, 32'(pslverr[d]), 32'd0);
            n++;
            @(negedge clk);
        end
        e = sb.pop_front();
        chk({tag, "/ready"}, 32'(pready[d]), 32'd1);
        chk({tag, "/latency"}, n, e.lat);
        chk({tag, "/slverr"}, 32'(pslverr[d]), 32'(e.err));
        if (e.rd) chk({tag, "/prdata"}, prdata[d], e.rdata);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        psel = 3'b000; penable = 1'b0;
    endtask

    initial begin
        rst = 1'b1; psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        @(negedge clk);
        chk("rst_prdata", prdata[0], 32'd0);
        chk("rst_pready", 32'(pready[0]), 32'd0);
        chk("rst_slverr", 32'(pslverr[0]), 32'd0);
        chk("rst_ctrl", ctrl[0], 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        xfer("id_read", 0, 0, 32'h8000_0000, 32'h0, 1'b0, 32'hA2B0_0001);
        xfer("wr_r1", 0, 1, 32'h8000_0004, 32'hDEAD_BEEF, 1'b0, 32'h0);
        idle();
        @(negedge clk);
        chk("ctrl_after_wr", ctrl[0], 32'hDEAD_BEEF);
        xfer("rd_r1", 0, 0, 32'h8000_0004, 32'h0, 1'b0, 32'hDEAD_BEEF);
        xfer("err_wr_r0", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0);
        xfer("err_idx16", 0, 0, 32'h8000_0040, 32'h0, 1'b1, 32'h0);
        xfer("err_unaligned", 0, 0, 32'h8000_0006, 32'h0, 1'b1, 32'h0);
        xfer("err_window", 0, 1, 32'h9000_0004, 32'h1234_5678, 1'b1, 32'h0);
        xfer("id_after_err", 0, 0, 32'h8000_0000, 32'h0, 1'b0, 32'hA2B0_0001);
        xfer("r1_after_err", 0, 0, 32'h8000_0004, 32'h0, 1'b0, 32'hDEAD_BEEF);
        idle();
        @(negedge clk);
        chk("ctrl_after_err", ctrl[0], 32'hDEAD_BEEF);

        xfer("ws0_wr", 1, 1, 32'h8000_0004, 32'hCAFE_0001, 1'b0, 32'h0);
        xfer("ws0_rd", 1, 0, 32'h8000_0004, 32'h0, 1'b0, 32'hCAFE_0001);
        xfer("ws3_wr", 2, 1, 32'h8000_0004, 32'hA5A5_0003, 1'b0, 32'h0);
        xfer("ws3_rd", 2, 0, 32'h8000_0004, 32'h0, 1'b0, 32'hA5A5_0003);
        idle();
        @(negedge clk);
        chk("ctrl_ws0", ctrl[1], 32'hCAFE_0001);
        chk("ctrl_ws3", ctrl[2], 32'hA5A5_0003);
        chk("ctrl_isolated", ctrl[0], 32'hDEAD_BEEF);

        // Drop Psel in the second wait cycle of a 3-wait-state write.
        @(posedge clk); #1;
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8000_0008; pwdata = 32'h1111_2222;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 3'b000; penable = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("abort_ready", 32'(pready[2]), 32'd0);
        end
        xfer("abort_rd_r2", 2, 0, 32'h8000_0008, 32'h0, 1'b0, 32'h0);
        idle();

        @(posedge clk); #1;
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8000_0008; pwdata = 32'h3333_4444;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_pready", 32'(pready[2]), 32'd0);
        chk("rst_mid_prdata", prdata[2], 32'd0);
        chk("rst_mid_slverr", 32'(pslverr[2]), 32'd0);
        chk("rst_mid_ctrl2", ctrl[2], 32'd0);
        chk("rst_mid_ctrl0", ctrl[0], 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; psel = 3'b000; penable = 1'b0;
        xfer("rst_rd_r2", 2, 0, 32'h8000_0008, 32'h0, 1'b0, 32'h0);
        xfer("rst_rd_r1", 2, 0, 32'h8000_0004, 32'h0, 1'b0, 32'h0);
        idle();

        @(posedge clk); #1;
        psel = 3'b001; penable = 1'b1; pwrite = 1'b0; paddr = 32'h8000_0000;
        repeat (4) begin
            @(negedge clk);
            chk("nosetup_ready", 32'(pready[0]), 32'd0);
        end
        idle();
        xfer("post_nosetup", 0, 0, 32'h8000_0000, 32'h0, 1'b0, 32'hA2B0_0001);
        idle();
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
APB responder at the far end of the bridge's APB initiator. Decodes one slave window and serves single read/write transfers against a small word-addressed register file. Inserts a configurable number of wait states via Pready and flags bad accesses via Pslverr. One instance per Pselx bit; register 1 is exported as a control word for downstream logic.

Parameters:
BASE_ADDR, 32'h8000_0000, window base; Paddr[31:ADDR_W] must equal BASE_ADDR[31:ADDR_W]
ADDR_W, 8, window size in address bits (256 bytes)
NUM_REGS, 16, number of 32-bit registers (2..64, NUM_REGS*4 <= 2**ADDR_W)
WAIT_STATES, 1, Pready-low cycles inserted in access phase (0..15)
ID_VALUE, 32'hA2B0_0001, read-only contents of register 0

Ports:
Hclk  in  1  system clock, all logic rising-edge
Hreset  in  1  asynchronous, active-high reset
Psel  in  1  slave select (this instance's Pselx bit)
Penable  in  1  APB access-phase strobe
Pwrite  in  1  1 = write, 0 = read
Paddr  in  32  byte address
Pwdata  in  32  write data
Prdata  out  32  read data, valid only when Pready=1 on a read
Pready  out  1  transfer-complete strobe
Pslverr  out  1  error response, valid only when Pready=1
ctrl_out  out  32  current contents of register 1

Behaviour:
- Reset (async, Hreset=1): state IDLE; Prdata=0, Pready=0, Pslverr=0; registers 1..NUM_REGS-1 = 0 (ctrl_out=0); wait counter=0. Reset mid-transfer aborts it with no register update.
- Index = Paddr[ADDR_W-1:2]. Error (err=1) if window mismatch, Paddr[1:0]!=0, index>=NUM_REGS, or write to index 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE: Pready=0. Setup phase (Psel=1, Penable=0) latches Paddr, Pwrite and err, loads counter=WAIT_STATES; next = WAIT if WAIT_STATES>0, else RESP. Psel=1 with Penable=1 in IDLE (no setup phase) is ignored and stays IDLE.
- WAIT: Pready=0; counter decrements each cycle; at counter==1 next = RESP. Psel=0 -> IDLE (abort, no write).
- RESP: Pready=1 for exactly one cycle; Pslverr=latched err. Read: Prdata = register[index] (ID_VALUE for index 0), or 0 if err. Write with err=0: register[index] <= Pwdata at the end of this cycle (Pwdata sampled here, not at setup). Write with err=1: no register change. Next = IDLE unconditionally. Psel=0 in RESP -> IDLE, no write, outputs still driven for the cycle.
- Outputs are registered. Prdata and Pslverr are 0 whenever Pready=0.
- Latency: setup cycle T0, access begins T1; Pready is high in cycle T1+WAIT_STATES. Total transfer = WAIT_STATES+2 cycles.
- Back-to-back: a new setup phase in the cycle after RESP is accepted from IDLE with no bubble beyond APB's mandatory setup cycle.
- Paddr and Pwrite changes during WAIT/RESP are ignored (latched values are used).
- ctrl_out updates in the cycle after the committing RESP edge.

Test Plan:
- Reset then read index 0 (Paddr=32'h8000_0000), WAIT_STATES=1 -> Pready low 1 cycle then high; Prdata=32'hA2B0_0001, Pslverr=0.
- Write 32'hDEAD_BEEF to 32'h8000_0004, then read it back -> Pslverr=0, Prdata=32'hDEAD_BEEF, ctrl_out=32'hDEAD_BEEF after the write completes.
- Errors: write to 32'h8000_0000, read of 32'h8000_0040 (index 16), access to 32'h8000_0006, access to 32'h9000_0004 -> each gets Pslverr=1 with Pready; Prdata=0; no register changes.
- WAIT_STATES=0 vs 3, back-to-back write then read -> Pready rises in the first access cycle vs the fourth; the second transfer's setup is accepted in the cycle after RESP.
- Abort: drop Psel during WAIT of a write to 32'h8000_0008 -> FSM returns to IDLE, Pready never asserts, register 2 unchanged. Repeat the abort by asserting Hreset mid-WAIT -> all outputs 0 immediately, register 2 = 0.
- Penable=1 with no prior setup cycle -> no response (Pready stays 0), FSM stays in IDLE.
